fetch_queue: RTL and testbench

- Instruction buffer between the I-cache/fetch unit and the decoder.
- Accepts fetched instruction words with their PC and predicted-taken bit. Presents them in order to the decoder as instruction/branch_taken/pc with a valid/ready handshake.
- Absorbs decoder stalls, discards instructions on a pipeline flush, and drops stale I-cache responses using a one-bit fetch epoch.

---
 rtl/fetch_queue_pkg.sv | 22 ++
 rtl/fetch_queue_if.sv | 23 ++
 rtl/fq_storage.sv | 22 ++
 rtl/fetch_queue.sv | 61 ++++++
 tb/tb_fetch_queue.sv | 115 +++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths and the fetch entry record used by the
// fetch queue and the later IF/ID register.
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
package fetch_queue_pkg;
  localparam int INSTR_W = `INSTRUCTION_SIZE;
  localparam int DATA_W  = `DATA_SIZE;
  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [DATA_W-1:0]  pc;
    logic               pred_taken;
  } fetch_entry_t;
  function automatic fetch_entry_t make_entry(input logic [INSTR_W-1:0] instruction,
                                              input logic [DATA_W-1:0] pc,
                                              input logic pred_taken);
    return '{instruction: instruction, pc: pc, pred_taken: pred_taken};
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decoder-side handshakes of the fetch queue.
interface fetch_queue_if;
  import fetch_queue_pkg::*;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instruction;
  logic [DATA_W-1:0]  in_pc;
  logic               in_pred_taken;
  logic               in_epoch;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instruction;
  logic               out_branch_taken;
  logic [DATA_W-1:0]  out_pc;
  modport master (
    output in_valid, in_instruction, in_pc, in_pred_taken, in_epoch, out_ready,
    input  in_ready, out_valid, out_instruction, out_branch_taken, out_pc
  );
  modport slave (
    input  in_valid, in_instruction, in_pc, in_pred_taken, in_epoch, out_ready,
    output in_ready, out_valid, out_instruction, out_branch_taken, out_pc
  );
endinterface

// File: rtl/fq_storage.sv
// fq_storage: DEPTH-entry register array, one write port, one asynchronous read port.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode with
// flush and one-bit epoch filtering of stale I-cache responses.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  fetch_queue_if.slave           fq,
  output logic                   cur_epoch,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             epoch_q, epoch_d, push, pop;
  fetch_entry_t     head;
  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (make_entry(fq.in_instruction, fq.in_pc, fq.in_pred_taken)),
    .raddr (rd_ptr_q),
    .rdata (head)
  );
  // Stale-epoch words are still accepted (in_ready) but never written.
  always_comb begin
    fq.in_ready         = count_q != FULL;
    fq.out_valid        = count_q != '0;
    push                = fq.in_valid & fq.in_ready & (fq.in_epoch == epoch_q) & ~flush;
    pop                 = fq.out_valid & fq.out_ready & ~flush;
    wr_ptr_d            = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d            = flush ? wr_ptr_q : pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d             = flush ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    epoch_d             = epoch_q ^ flush;
    fq.out_instruction  = fq.out_valid ? head.instruction : '0;
    fq.out_pc           = fq.out_valid ? head.pc : '0;
    fq.out_branch_taken = fq.out_valid & head.pred_taken;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      epoch_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      epoch_q  <= epoch_d;
    end
  end
  assign cur_epoch = epoch_q;
  assign count     = count_q;
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n) !(push && count_q == FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n) !(pop && count_q == '0));
  a_count_bound:  assert property (@(posedge clk) disable iff (!reset_n) count_q <= FULL);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus checked against a queue-based
// reference model of the fetch queue.
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic cur_epoch;
  logic [$clog2(DEPTH):0] count;
  fetch_queue_if fq();
  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .fq        (fq),
    .cur_epoch (cur_epoch),
    .count     (count)
  );
  always #5 clk = ~clk;
  fetch_entry_t mq[$];
  bit m_epoch = 1'b0;
  int errors = 0;
  int checks = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_state();
    fetch_entry_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    chk("out_valid", 64'(fq.out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(fq.in_ready), 64'(mq.size() != DEPTH));
    chk("count", 64'(count), 64'(mq.size()));
    chk("cur_epoch", 64'(cur_epoch), 64'(m_epoch));
    chk("out_pc", 64'(fq.out_pc), 64'(h.pc));
    chk("out_instruction", 64'(fq.out_instruction), 64'(h.instruction));
    chk("out_branch_taken", 64'(fq.out_branch_taken), 64'(h.pred_taken));
  endtask
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit pt, input bit ep, input bit fl, input bit rdy);
    bit do_push, do_pop;
    fq.in_valid = v; fq.in_instruction = ins; fq.in_pc = pc;
    fq.in_pred_taken = pt; fq.in_epoch = ep; flush = fl; fq.out_ready = rdy;
    @(negedge clk);
    check_state();
    do_push = v && mq.size() < DEPTH && ep == m_epoch && !fl;
    do_pop  = mq.size() > 0 && rdy && !fl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_epoch = ~m_epoch;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(make_entry(ins, pc, pt));
    end
    #1;
  endtask
  initial begin
    fq.in_valid = 0; fq.in_instruction = '0; fq.in_pc = '0;
    fq.in_pred_taken = 0; fq.in_epoch = 0; fq.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0);
    // fill to full, try a fifth word, then drain in order
    for (int i = 0; i < 5; i++) step(1, 32'hA000 + i, 32'h1000 + 4 * i, i[0], 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);
    // streaming with pointer wrap
    for (int i = 0; i < 10; i++) step(1, $urandom, 32'h3000 + 4 * i, 1'($urandom), 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // flush with three queued, stale word dropped, new-epoch word passes
    for (int i = 0; i < 3; i++) step(1, $urandom, 32'h1100 + 4 * i, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 32'hDEAD, 32'h1F00, 1, 0, 0, 0);
    step(1, 32'hBEEF, 32'h2000, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    // flush while pushing and popping
    step(1, 32'h11, 32'h2100, 0, 1, 0, 0);
    step(1, 32'h22, 32'h2104, 0, 1, 0, 1);
    step(1, 32'h33, 32'h2108, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // random traffic with stale words and flushes
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom),
           ($urandom_range(0, 7) == 0) ? ~m_epoch : m_epoch,
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    // async reset with three taken-branch entries queued
    while (mq.size() != 0) step(0, 0, 0, 0, m_epoch, 0, 1);
    for (int i = 0; i < 3; i++) step(1, $urandom, 32'h4000 + 4 * i, 1, m_epoch, 0, 0);
    fq.in_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(fq.out_valid), 64'd0);
    chk("rst_branch_taken", 64'(fq.out_branch_taken), 64'd0);
    chk("rst_epoch", 64'(cur_epoch), 64'd0);
    mq.delete();
    m_epoch = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h5555, 32'h5000, 0, 0, 0, 0);
    step(1, 32'h6666, 32'h5004, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check_state();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
